// File: rtl/rt_dma_pkg.sv
// Shared definitions for the simple-mode DMA register block:
// register offsets, bit positions, channel states, command bundle.
package rt_dma_pkg;

  localparam int DMA_MEM_AW = 36;
  localparam int DMA_LEN_W  = 26;

  localparam logic [6:0] OFF_DMACR = 7'h00;
  localparam logic [6:0] OFF_DMASR = 7'h04;
  localparam logic [6:0] OFF_ADDR  = 7'h18;
  localparam logic [6:0] OFF_MSB   = 7'h1C;
  localparam logic [6:0] OFF_LEN   = 7'h28;
  localparam logic [6:0] S2MM_BASE = 7'h30;
  localparam logic [6:0] MAP_END   = 7'h60;

  localparam int CR_RS     = 0;
  localparam int CR_RESET  = 2;
  localparam int CR_IOC_EN = 12;
  localparam int CR_ERR_EN = 14;
  localparam int SR_IOC    = 12;
  localparam int SR_ERR    = 14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    CH_HALTED,
    CH_IDLE,
    CH_CMD,
    CH_BUSY
  } chan_state_t;

  typedef struct packed {
    logic [DMA_MEM_AW-1:0] addr;
    logic [DMA_LEN_W-1:0]  len;
  } dma_cmd_t;

  function automatic logic is_reg(input logic [6:0] off);
    return (off == OFF_DMACR) || (off == OFF_DMASR) ||
           (off == OFF_ADDR)  || (off == OFF_MSB)   ||
           (off == OFF_LEN);
  endfunction

  function automatic logic [31:0] merge_strb(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rt_dma_ctrl_slave_if.sv
// AXI4-Lite bundle between the PS master port and the DMA
// register block.
interface rt_dma_ctrl_slave_if #(
  parameter int ADDR_W = 7
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/rt_dma_chan_regs.sv
// One DMA channel: DMACR/DMASR/ADDR/MSB/LENGTH registers,
// command/status FSM and interrupt output.
module rt_dma_chan_regs
  import rt_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_rst,
  input  logic        wr_en,
  input  logic [6:0]  wr_off,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [6:0]  rd_off,
  output logic [31:0] rd_data,
  output logic        soft_req,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output dma_cmd_t    cmd,
  input  logic        sts_valid,
  input  logic        sts_err,
  output logic        irq
);

  chan_state_t state_q, state_d;
  dma_cmd_t    cmd_q, cmd_d;
  logic        rs_q, rs_d;
  logic        ioc_en_q, ioc_en_d;
  logic        err_en_q, err_en_d;
  logic [7:0]  thr_q, thr_d;
  logic        int_err_q, int_err_d;
  logic        slv_err_q, slv_err_d;
  logic        ioc_irq_q, ioc_irq_d;
  logic        err_irq_q, err_irq_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  msb_q, msb_d;
  logic [25:0] len_q, len_d;
  logic [25:0] len_w;
  logic        len_wr;
  logic        launch_ok;

  // Register writes, W1C status, FSM and soft-reset override.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rs_d      = rs_q;
    ioc_en_d  = ioc_en_q;
    err_en_d  = err_en_q;
    thr_d     = thr_q;
    int_err_d = int_err_q;
    slv_err_d = slv_err_q;
    ioc_irq_d = ioc_irq_q;
    err_irq_d = err_irq_q;
    addr_d    = addr_q;
    msb_d     = msb_q;
    len_d     = len_q;
    len_w     = len_q;
    len_wr    = wr_en && (wr_off == OFF_LEN);
    soft_req  = wr_en && (wr_off == OFF_DMACR) &&
                wstrb[0] && wdata[CR_RESET];

    if (wr_en && wr_off == OFF_DMACR) begin
      if (wstrb[0]) rs_d = wdata[CR_RS];
      if (wstrb[1]) begin
        ioc_en_d = wdata[CR_IOC_EN];
        err_en_d = wdata[CR_ERR_EN];
      end
      if (wstrb[2]) thr_d = wdata[23:16];
    end

    if (wr_en && wr_off == OFF_DMASR && wstrb[1]) begin
      if (wdata[SR_IOC]) ioc_irq_d = 1'b0;
      if (wdata[SR_ERR]) err_irq_d = 1'b0;
    end

    if (wr_en && wr_off == OFF_ADDR)
      addr_d = merge_strb(addr_q, wdata, wstrb);

    if (wr_en && wr_off == OFF_MSB && wstrb[0])
      msb_d = wdata[3:0];

    if (wstrb[0]) len_w[7:0]   = wdata[7:0];
    if (wstrb[1]) len_w[15:8]  = wdata[15:8];
    if (wstrb[2]) len_w[23:16] = wdata[23:16];
    if (wstrb[3]) len_w[25:24] = wdata[25:24];
    if (len_wr) len_d = len_w;

    launch_ok = (state_q == CH_IDLE) && rs_q &&
                (len_w != '0);
    // Status sets follow the W1C clears so a set wins.
    if (len_wr && !launch_ok) begin
      int_err_d = 1'b1;
      err_irq_d = 1'b1;
    end

    unique case (state_q)
      CH_HALTED: begin
        if (rs_q) state_d = CH_IDLE;
      end
      CH_IDLE: begin
        if (!rs_q) begin
          state_d = CH_HALTED;
        end else if (len_wr && launch_ok) begin
          state_d    = CH_CMD;
          cmd_d.addr = {msb_q, addr_q};
          cmd_d.len  = len_w;
        end
      end
      CH_CMD: begin
        if (cmd_ready) state_d = CH_BUSY;
      end
      CH_BUSY: begin
        if (sts_valid) begin
          if (sts_err) begin
            slv_err_d = 1'b1;
            err_irq_d = 1'b1;
            rs_d      = 1'b0;
            state_d   = CH_HALTED;
          end else begin
            ioc_irq_d = 1'b1;
            state_d   = rs_q ? CH_IDLE : CH_HALTED;
          end
        end
      end
      default: state_d = CH_HALTED;
    endcase

    if (soft_rst) begin
      state_d   = CH_HALTED;
      cmd_d     = '0;
      rs_d      = 1'b0;
      ioc_en_d  = 1'b0;
      err_en_d  = 1'b0;
      thr_d     = 8'h01;
      int_err_d = 1'b0;
      slv_err_d = 1'b0;
      ioc_irq_d = 1'b0;
      err_irq_d = 1'b0;
      addr_d    = '0;
      msb_d     = '0;
      len_d     = '0;
    end
  end

  // Channel state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CH_HALTED;
      cmd_q     <= '0;
      rs_q      <= 1'b0;
      ioc_en_q  <= 1'b0;
      err_en_q  <= 1'b0;
      thr_q     <= 8'h01;
      int_err_q <= 1'b0;
      slv_err_q <= 1'b0;
      ioc_irq_q <= 1'b0;
      err_irq_q <= 1'b0;
      addr_q    <= '0;
      msb_q     <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rs_q      <= rs_d;
      ioc_en_q  <= ioc_en_d;
      err_en_q  <= err_en_d;
      thr_q     <= thr_d;
      int_err_q <= int_err_d;
      slv_err_q <= slv_err_d;
      ioc_irq_q <= ioc_irq_d;
      err_irq_q <= err_irq_d;
      addr_q    <= addr_d;
      msb_q     <= msb_d;
      len_q     <= len_d;
    end
  end

  // Readback reflects current flops, i.e. pre-write values.
  always_comb begin
    rd_data = '0;
    case (rd_off)
      OFF_DMACR: rd_data = {8'h00, thr_q, 1'b0, err_en_q,
                            1'b0, ioc_en_q, 11'h000, rs_q};
      OFF_DMASR: rd_data = {17'h0, err_irq_q, 1'b0,
                            ioc_irq_q, 6'h00, slv_err_q,
                            int_err_q, 2'b00,
                            state_q == CH_IDLE, !rs_q};
      OFF_ADDR:  rd_data = addr_q;
      OFF_MSB:   rd_data = {28'h0, msb_q};
      OFF_LEN:   rd_data = {6'h00, len_q};
      default:   rd_data = '0;
    endcase
  end

  assign cmd_valid = (state_q == CH_CMD);
  assign cmd       = cmd_q;
  assign irq       = (ioc_irq_q & ioc_en_q) |
                     (err_irq_q & err_en_q);

endmodule

// File: rtl/rt_dma_ctrl_slave.sv
// AXI4-Lite responder for the simple-mode DMA register map;
// MM2S registers at 0x00, S2MM registers at 0x30.
module rt_dma_ctrl_slave
  import rt_dma_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int MEM_ADDR_W = 36,
  parameter int LEN_W      = 26
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  rt_dma_ctrl_slave_if.slave         s,
  output logic [1:0]                 cmd_valid,
  input  logic [1:0]                 cmd_ready,
  output logic [1:0][MEM_ADDR_W-1:0] cmd_addr,
  output logic [1:0][LEN_W-1:0]      cmd_len,
  input  logic [1:0]                 sts_valid,
  output logic [1:0]                 sts_ready,
  input  logic [1:0]                 sts_err,
  output logic [1:0]                 irq
);

  logic              rdy_q, rdy_d;
  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_held_q, w_held_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [6:0]        wa, ra, w_off, r_off;
  logic              w_sel, w_hit, r_sel, r_hit, commit;
  logic [1:0]        ch_wr, ch_soft;
  logic [1:0][31:0]  ch_rd;
  dma_cmd_t          ch_cmd [2];
  logic              soft_rst;

  assign wa    = aw_addr_q;
  assign ra    = s.araddr;
  assign w_sel = (wa >= S2MM_BASE);
  assign w_off = w_sel ? wa - S2MM_BASE : wa;
  assign w_hit = (wa < MAP_END) && is_reg(w_off);
  assign r_sel = (ra >= S2MM_BASE);
  assign r_off = r_sel ? ra - S2MM_BASE : ra;
  assign r_hit = (ra < MAP_END) && is_reg(r_off);

  assign commit   = aw_held_q && w_held_q;
  assign soft_rst = |ch_soft;

  assign s.awready = rdy_q && !aw_held_q && !bvalid_q;
  assign s.wready  = rdy_q && !w_held_q && !bvalid_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = rdy_q && !rvalid_q;
  assign s.rvalid  = rvalid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign sts_ready = 2'b11;

  // AW/W capture, single-outstanding commit, B and R channels.
  always_comb begin
    rdy_d     = 1'b1;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (s.awvalid && s.awready) begin
      aw_held_d = 1'b1;
      aw_addr_d = s.awaddr;
    end
    if (s.wvalid && s.wready) begin
      w_held_d = 1'b1;
      w_data_d = s.wdata;
      w_strb_d = s.wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = w_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s.bready) begin
      bvalid_d = 1'b0;
    end

    if (s.arvalid && s.arready) begin
      rvalid_d = 1'b1;
      rdata_d  = r_hit ? ch_rd[r_sel] : '0;
      rresp_d  = r_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Bus-side state register with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdy_q     <= rdy_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    assign ch_wr[c] = commit && w_hit && (w_sel == 1'(c));

    rt_dma_chan_regs u_ch (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .soft_rst  (soft_rst),
      .wr_en     (ch_wr[c]),
      .wr_off    (w_off),
      .wdata     (w_data_q),
      .wstrb     (w_strb_q),
      .rd_off    (r_off),
      .rd_data   (ch_rd[c]),
      .soft_req  (ch_soft[c]),
      .cmd_valid (cmd_valid[c]),
      .cmd_ready (cmd_ready[c]),
      .cmd       (ch_cmd[c]),
      .sts_valid (sts_valid[c]),
      .sts_err   (sts_err[c]),
      .irq       (irq[c])
    );

    assign cmd_addr[c] = ch_cmd[c].addr;
    assign cmd_len[c]  = ch_cmd[c].len;
  end

endmodule

// File: tb/tb_rt_dma_ctrl_slave.sv
// Scoreboard bench for rt_dma_ctrl_slave: directed AXI-Lite
// traffic, expected B/R/command responses queued and checked.
module tb_rt_dma_ctrl_slave;
  import rt_dma_pkg::*;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic [1:0]        cmd_valid, cmd_ready;
  logic [1:0][35:0]  cmd_addr;
  logic [1:0][25:0]  cmd_len;
  logic [1:0]        sts_valid, sts_ready, sts_err, irq;

  rt_dma_ctrl_slave_if #(.ADDR_W(7)) bus ();

  rt_dma_ctrl_slave dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .s         (bus),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .sts_valid (sts_valid),
    .sts_ready (sts_ready),
    .sts_err   (sts_err),
    .irq       (irq)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int       n_cmp = 0;
  int       n_bad = 0;
  rexp_t    rq[$];
  logic [1:0] bq[$];
  dma_cmd_t cq0[$];
  dma_cmd_t cq1[$];

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event absent or unexpected", nm);
  endfunction

  function automatic dma_cmd_t mk(input logic [35:0] a,
                                  input logic [25:0] l);
    dma_cmd_t c;
    c.addr = a;
    c.len  = l;
    return c;
  endfunction

  // Monitor: pops and compares on every completed handshake.
  always @(negedge ap_clk) begin
    rexp_t    re;
    logic [1:0] be;
    dma_cmd_t ce;
    if (!ap_rst) begin
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) miss("r_extra");
        else begin
          re = rq.pop_front();
          chk("rdata", bus.rdata, re.data);
          chk("rresp", bus.rresp, re.resp);
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) miss("b_extra");
        else begin
          be = bq.pop_front();
          chk("bresp", bus.bresp, be);
        end
      end
      if (cmd_valid[0] && cmd_ready[0]) begin
        if (cq0.size() == 0) miss("cmd0_extra");
        else begin
          ce = cq0.pop_front();
          chk("cmd0_addr", cmd_addr[0], ce.addr);
          chk("cmd0_len", cmd_len[0], ce.len);
        end
      end
      if (cmd_valid[1] && cmd_ready[1]) begin
        if (cq1.size() == 0) miss("cmd1_extra");
        else begin
          ce = cq1.pop_front();
          chk("cmd1_addr", cmd_addr[1], ce.addr);
          chk("cmd1_len", cmd_len[1], ce.len);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wr(input logic [6:0]  a,
                    input logic [31:0] d,
                    input logic [3:0]  st = 4'hF,
                    input logic [1:0]  er = RESP_OKAY,
                    input int          lead = 0,
                    input int          bhold = 0);
    int   n;
    int   held;
    logic hs;
    bq.push_back(er);
    if (bhold > 0) bus.bready = 1'b0;
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge ap_clk); hs = bus.awready; tick(); n++;
    end
    bus.awvalid = 1'b0;
    if (!hs) miss("aw_timeout");
    repeat (lead) tick();
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    bus.wstrb  = st;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge ap_clk); hs = bus.wready; tick(); n++;
    end
    bus.wvalid = 1'b0;
    if (!hs) miss("w_timeout");
    if (bhold > 0) begin
      n = 0;
      while (!bus.bvalid && n < 50) begin tick(); n++; end
      held = 0;
      repeat (bhold) begin
        tick();
        held += int'(bus.bvalid);
      end
      chk("bvalid_held", held, bhold);
      bus.bready = 1'b1;
    end
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge ap_clk);
      hs = bus.bvalid && bus.bready;
      tick(); n++;
    end
    if (!hs) miss("b_timeout");
  endtask

  task automatic rd(input logic [6:0]  a,
                    input logic [31:0] d,
                    input logic [1:0]  r = RESP_OKAY);
    rexp_t e;
    int    n;
    logic  hs;
    e.data = d;
    e.resp = r;
    rq.push_back(e);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge ap_clk); hs = bus.arready; tick(); n++;
    end
    bus.arvalid = 1'b0;
    if (!hs) miss("ar_timeout");
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge ap_clk); hs = bus.rvalid; tick(); n++;
    end
    if (!hs) miss("r_timeout");
  endtask

  task automatic pulse_cmd(input int c);
    cmd_ready[c] = 1'b1;
    tick();
    cmd_ready[c] = 1'b0;
  endtask

  task automatic pulse_sts(input int c, input logic e);
    sts_valid[c] = 1'b1;
    sts_err[c]   = e;
    tick();
    sts_valid[c] = 1'b0;
    sts_err[c]   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0;
    bus.wstrb   = '0;   bus.bready = 1'b1;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready  = 1'b1;
    cmd_ready = '0; sts_valid = '0; sts_err = '0;
    ap_rst = 1'b1;
    repeat (3) tick();
    chk("rst_irq", irq, 2'b00);
    chk("rst_cmd_valid", cmd_valid, 2'b00);
    chk("rst_sts_ready", sts_ready, 2'b11);
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    ap_rst = 1'b0;
    tick();

    rd(7'h04, 32'h0000_0001);
    rd(7'h34, 32'h0000_0001);
    rd(7'h00, 32'h0001_0000);

    // MM2S normal transfer, frozen command, busy length error
    wr(7'h00, 32'h0001_1003);
    rd(7'h00, 32'h0001_1001);
    wr(7'h18, 32'h8000_0000);
    wr(7'h1C, 32'h0000_0008);
    cq0.push_back(mk(36'h8_8000_0000, 26'd32));
    wr(7'h28, 32'd32);
    chk("mm2s_cmd_valid", cmd_valid, 2'b01);
    rd(7'h04, 32'h0000_0000);
    wr(7'h18, 32'h1234_0000);
    rd(7'h18, 32'h1234_0000);
    pulse_cmd(0);
    chk("mm2s_cmd_drop", cmd_valid, 2'b00);
    wr(7'h28, 32'd32);
    chk("busy_len_nocmd", cmd_valid, 2'b00);
    pulse_sts(0, 1'b0);
    rd(7'h04, 32'h0000_5012);
    chk("ioc_irq", irq, 2'b01);
    wr(7'h04, 32'hFFFF_FFFF);
    rd(7'h04, 32'h0000_0012);
    chk("ioc_clr_irq", irq, 2'b00);
    wr(7'h28, 32'h0);
    chk("len0_nocmd", cmd_valid, 2'b00);
    rd(7'h04, 32'h0000_4012);
    rd(7'h28, 32'h0);
    wr(7'h04, 32'h0000_4000, 4'b0010);
    rd(7'h04, 32'h0000_0012);
    wr(7'h18, 32'hAABB_CCDD, 4'b0101);
    rd(7'h18, 32'h12BB_00DD);

    // S2MM transfer completing with a slave error
    wr(7'h30, 32'h0001_5003);
    wr(7'h48, 32'hC000_0010);
    wr(7'h4C, 32'hFFFF_FFF8);
    cq1.push_back(mk(36'h8_C000_0010, 26'd16));
    wr(7'h58, 32'hFC00_0010);
    chk("s2mm_cmd_valid", cmd_valid, 2'b10);
    rd(7'h4C, 32'h0000_0008);
    rd(7'h58, 32'h0000_0010);
    pulse_cmd(1);
    pulse_sts(1, 1'b1);
    rd(7'h34, 32'h0000_4021);
    chk("err_irq", irq, 2'b10);
    rd(7'h30, 32'h0001_5000);
    wr(7'h34, 32'h0000_4000);
    rd(7'h34, 32'h0000_0021);
    chk("err_clr_irq", irq, 2'b00);

    // Unmapped offsets, delayed W and back-pressured B
    wr(7'h60, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 3, 4);
    wr(7'h2C, 32'h1111_1111, 4'hF, RESP_SLVERR);
    rd(7'h60, 32'h0, RESP_SLVERR);
    rd(7'h2C, 32'h0, RESP_SLVERR);

    // Soft reset while S2MM is busy
    wr(7'h30, 32'h0001_5001);
    cq1.push_back(mk(36'h8_C000_0010, 26'd16));
    wr(7'h58, 32'd16);
    pulse_cmd(1);
    wr(7'h00, 32'h0000_0004);
    pulse_sts(1, 1'b0);
    rd(7'h04, 32'h0000_0001);
    rd(7'h34, 32'h0000_0001);
    rd(7'h00, 32'h0001_0000);
    rd(7'h30, 32'h0001_0000);
    rd(7'h48, 32'h0);
    rd(7'h58, 32'h0);
    chk("srst_irq", irq, 2'b00);
    chk("srst_cmd_valid", cmd_valid, 2'b00);

    repeat (5) tick();
    chk("rq_left", rq.size(), 0);
    chk("bq_left", bq.size(), 0);
    chk("cq0_left", cq0.size(), 0);
    chk("cq1_left", cq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
